vreg_dump_serializer: RTL and testbench

- Read-side companion of the vector register file.
- On command, it walks a contiguous (optionally wrapping) range of vector registers through one RF read port.
- Each BITS-wide register is captured and emitted as BITS/WORD words over a valid/ready stream.
- Used for AES state/round-key readback to host/debug logic and memory store paths.

---
 rtl/vreg_dump_serializer_if.sv | 15 +
 rtl/vreg_dump_serializer.sv | 98 +++++++++
 tb/tb_vreg_dump_serializer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/vreg_dump_serializer_if.sv
// Word stream out of the vector register dump; every word is tagged with its source register.
// The master holds all fields stable while out_valid is high and out_ready is low.
interface vreg_dump_serializer_if #(
  parameter int WORD = 32,
  parameter int AW   = 4
);
  logic [WORD-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic [AW-1:0]   out_reg_idx;

  modport master (output out_data, out_valid, out_last, out_reg_idx, input out_ready);
  modport slave  (input out_data, out_valid, out_last, out_reg_idx, output out_ready);
endinterface

// File: rtl/vreg_dump_serializer.sv
// Dumps a register range MS-word first; first word 2 edges after start, one bubble per register.
// Backpressure: out_ready low freezes the presented word; full rate is one word per cycle.
module vreg_dump_serializer #(
  parameter  int DEPTH = 16,
  parameter  int BITS  = 128,
  parameter  int WORD  = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         first_reg,
  input  logic [AW-1:0]         last_reg,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         rf_address,
  input  logic [BITS-1:0]       rf_read,
  vreg_dump_serializer_if.master out
);
  localparam int NW = BITS / WORD;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, SEND, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   last_q;
  logic [AW-1:0]   reg_idx_q;
  logic [BITS-1:0] buffer;
  logic [CW-1:0]   word_cnt;
  logic            hs;
  logic            final_word;
  logic            final_reg;

  assign hs         = (state == SEND) && out.out_ready;
  assign final_word = (word_cnt == CW'(NW - 1));
  assign final_reg  = (rf_address == last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADDR;
      ADDR:    state_nxt = SEND;
      SEND:    if (hs && final_word) state_nxt = final_reg ? DONE : ADDR;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The buffer shifts left on each accepted word so the next word is always at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= '0;
      rf_address <= '0;
      reg_idx_q  <= '0;
      buffer     <= '0;
      word_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            last_q     <= last_reg;
            rf_address <= first_reg;
          end
        end
        ADDR: begin
          buffer    <= rf_read;
          word_cnt  <= '0;
          reg_idx_q <= rf_address;
        end
        SEND: begin
          if (hs) begin
            if (!final_word) begin
              buffer   <= buffer << WORD;
              word_cnt <= word_cnt + CW'(1);
            end else if (!final_reg) begin
              rf_address <= (rf_address == AW'(DEPTH - 1)) ? '0 : rf_address + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy            = (state != IDLE);
    done            = (state == DONE);
    out.out_valid   = (state == SEND);
    out.out_last    = (state == SEND) && final_word && final_reg;
    out.out_data    = buffer[BITS-1 -: WORD];
    out.out_reg_idx = reg_idx_q;
  end
endmodule

// File: tb/tb_vreg_dump_serializer.sv
// Directed bench for vreg_dump_serializer with a behavioural register file behind the read port.
module tb_vreg_dump_serializer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   first_reg = '0;
  logic [3:0]   last_reg = '0;
  logic         busy, done;
  logic [3:0]   rf_address;
  logic [127:0] rf_read;
  logic [127:0] rf [16];

  vreg_dump_serializer_if #(.WORD(32), .AW(4)) sif ();

  vreg_dump_serializer #(.DEPTH(16), .BITS(128), .WORD(32)) dut (
    .clk(clk), .rst(rst), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .busy(busy), .done(done), .rf_address(rf_address), .rf_read(rf_read), .out(sif.master)
  );

  always #5 clk = ~clk;
  assign rf_read = rf[rf_address];

  int checks = 0;
  int failures = 0;
  logic [31:0] got_data [64];
  logic [3:0]  got_idx  [64];
  logic        got_last [64];
  int nw, done_cnt, first_valid, done_cyc, hold_err;
  logic busy_after, timeout;

  function automatic logic [31:0] pat(int k, int w);
    return {16'hA5A5, 8'(k), 8'(w)};
  endfunction

  task automatic init_rf();
    for (int k = 0; k < 16; k++)
      for (int w = 0; w < 4; w++)
        rf[k][127-32*w -: 32] = pat(k, w);
  endtask

  // Called at a negedge; returns at the negedge right after the start edge.
  task automatic do_start(input logic [3:0] f, input logic [3:0] l);
    sif.out_ready = 1'b1;
    first_reg = f;
    last_reg  = l;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input int budget, input bit toggle, input int inj_cyc, input bit inj_done);
    logic [31:0] pd;
    logic [3:0]  pi;
    logic        pl;
    bit          have_prev;
    nw = 0; done_cnt = 0; first_valid = -1; done_cyc = -1; hold_err = 0;
    busy_after = 1'bx; timeout = 1'b1; have_prev = 0;
    pd = '0; pi = '0; pl = 1'b0;
    for (int c = 0; c < budget; c++) begin
      start = 1'b0;
      if (done_cyc >= 0) begin
        busy_after = busy;
        timeout = 1'b0;
        break;
      end
      sif.out_ready = toggle ? (c % 2 == 1) : 1'b1;
      if (sif.out_valid && first_valid < 0) first_valid = c;
      if (have_prev && (!sif.out_valid || sif.out_data !== pd || sif.out_reg_idx !== pi ||
                        sif.out_last !== pl)) hold_err++;
      have_prev = sif.out_valid && !sif.out_ready;
      pd = sif.out_data; pi = sif.out_reg_idx; pl = sif.out_last;
      if (sif.out_valid && sif.out_ready && nw < 64) begin
        got_data[nw] = sif.out_data;
        got_idx[nw]  = sif.out_reg_idx;
        got_last[nw] = sif.out_last;
        nw++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
        if (inj_done) begin first_reg = 4'd7; last_reg = 4'd7; start = 1'b1; end
      end else if (c == inj_cyc) begin
        first_reg = 4'd7; last_reg = 4'd7; start = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (sif.out_valid !== 1'b0 || sif.out_last !== 1'b0) begin failures++; $display("FAIL reset_valid_last got=%b%b exp=00", sif.out_valid, sif.out_last); end
    checks++; if (sif.out_data !== 32'h0 || rf_address !== 4'h0 || sif.out_reg_idx !== 4'h0) begin
      failures++; $display("FAIL reset_data_addr got=%h/%h/%h exp=0/0/0", sif.out_data, rf_address, sif.out_reg_idx); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    rf[1] = {4{32'hBBBBBBBB}};
    do_start(4'd1, 4'd1);
    checks++; if (busy !== 1'b1 || sif.out_valid !== 1'b0) begin failures++; $display("FAIL single_addr_cycle got busy=%b valid=%b exp busy=1 valid=0", busy, sif.out_valid); end
    collect(50, 1'b0, -1, 1'b0);
    checks++; if (timeout) begin failures++; $display("FAIL single_timeout got=no_done exp=done"); end
    checks++; if (first_valid !== 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", first_valid); end
    checks++; if (nw !== 4) begin failures++; $display("FAIL single_nwords got=%0d exp=4", nw); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_data[i] !== 32'hBBBBBBBB || got_idx[i] !== 4'd1 || got_last[i] !== (i == 3)) begin
        failures++; $display("FAIL single_word%0d got=%h/%0d/%b exp=bbbbbbbb/1/%b", i, got_data[i], got_idx[i], got_last[i], i == 3); end
    end
    checks++; if (done_cyc !== 5 || done_cnt !== 1) begin failures++; $display("FAIL single_done got cyc=%0d cnt=%0d exp cyc=5 cnt=1", done_cyc, done_cnt); end
    checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", busy_after); end
  endtask

  task automatic test_two_regs();
    rf[5] = {4{32'hCCCCCCCC}};
    rf[6] = {4{32'hDDDDDDDD}};
    do_start(4'd5, 4'd6);
    collect(80, 1'b0, -1, 1'b0);
    checks++; if (timeout || nw !== 8) begin failures++; $display("FAIL two_nwords got=%0d exp=8", nw); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got_data[i] !== ((i < 4) ? 32'hCCCCCCCC : 32'hDDDDDDDD) || got_idx[i] !== ((i < 4) ? 4'd5 : 4'd6) ||
          got_last[i] !== (i == 7)) begin
        failures++; $display("FAIL two_word%0d got=%h/%0d/%b", i, got_data[i], got_idx[i], got_last[i]); end
    end
    checks++; if (done_cyc !== 10) begin failures++; $display("FAIL two_cycles got=%0d exp=10", done_cyc); end
  endtask

  task automatic test_wrap();
    init_rf();
    do_start(4'd14, 4'd1);
    collect(120, 1'b0, -1, 1'b0);
    checks++; if (timeout || nw !== 16) begin failures++; $display("FAIL wrap_nwords got=%0d exp=16", nw); end
    for (int i = 0; i < 16; i++) begin
      int r;
      r = (14 + i / 4) % 16;
      checks++;
      if (got_data[i] !== pat(r, i % 4) || got_idx[i] !== 4'(r) || got_last[i] !== (i == 15)) begin
        failures++; $display("FAIL wrap_word%0d got=%h/%0d/%b exp=%h/%0d/%b", i, got_data[i], got_idx[i], got_last[i], pat(r, i % 4), r, i == 15); end
    end
    checks++; if (done_cyc !== 20) begin failures++; $display("FAIL wrap_cycles got=%0d exp=20", done_cyc); end
  endtask

  task automatic test_full_range();
    do_start(4'd0, 4'd15);
    collect(300, 1'b0, -1, 1'b0);
    checks++; if (timeout || nw !== 64 || done_cyc !== 80) begin failures++; $display("FAIL full_range got words=%0d cyc=%0d exp words=64 cyc=80", nw, done_cyc); end
    checks++; if (got_data[63] !== pat(15, 3) || got_idx[63] !== 4'd15 || got_last[63] !== 1'b1 || got_last[59] !== 1'b0) begin
      failures++; $display("FAIL full_range_tail got=%h/%0d/%b exp=%h/15/1", got_data[63], got_idx[63], got_last[63], pat(15, 3)); end
  endtask

  task automatic test_backpressure();
    rf[10] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    do_start(4'd10, 4'd10);
    collect(80, 1'b1, -1, 1'b0);
    checks++; if (timeout || nw !== 4) begin failures++; $display("FAIL bp_nwords got=%0d exp=4", nw); end
    checks++; if (got_data[0] !== 32'h00112233 || got_data[1] !== 32'h44556677 ||
                  got_data[2] !== 32'h8899AABB || got_data[3] !== 32'hCCDDEEFF) begin
      failures++; $display("FAIL bp_order got=%h %h %h %h exp=00112233 44556677 8899aabb ccddeeff", got_data[0], got_data[1], got_data[2], got_data[3]); end
    checks++; if (hold_err !== 0) begin failures++; $display("FAIL bp_hold got=%0d exp=0", hold_err); end
    checks++; if (got_last[3] !== 1'b1 || got_last[2] !== 1'b0) begin failures++; $display("FAIL bp_last got=%b%b exp=01", got_last[2], got_last[3]); end
  endtask

  task automatic test_start_ignored();
    int extra_busy;
    do_start(4'd3, 4'd4);
    collect(80, 1'b0, 3, 1'b1);
    checks++; if (timeout || nw !== 8 || done_cnt !== 1) begin failures++; $display("FAIL ign_count got words=%0d dones=%0d exp words=8 dones=1", nw, done_cnt); end
    checks++; if (got_idx[0] !== 4'd3 || got_idx[7] !== 4'd4 || got_data[4] !== pat(4, 0)) begin
      failures++; $display("FAIL ign_range got=%0d/%0d/%h exp=3/4/%h", got_idx[0], got_idx[7], got_data[4], pat(4, 0)); end
    extra_busy = (busy_after === 1'b1) ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) extra_busy++;
    end
    checks++; if (extra_busy !== 0) begin failures++; $display("FAIL ign_done_start got=%0d busy_cycles exp=0", extra_busy); end
  endtask

  task automatic test_reset_mid();
    do_start(4'd12, 4'd12);
    @(negedge clk);
    @(negedge clk);
    checks++; if (sif.out_valid !== 1'b1 || sif.out_data !== pat(12, 1)) begin
      failures++; $display("FAIL mid_second_word got=%b/%h exp=1/%h", sif.out_valid, sif.out_data, pat(12, 1)); end
    #2 rst = 1'b1;
    #1;
    checks++; if (sif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sif.out_last !== 1'b0) begin
      failures++; $display("FAIL mid_async_reset got valid=%b busy=%b done=%b last=%b exp=0000", sif.out_valid, busy, done, sif.out_last); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(4'd12, 4'd12);
    collect(50, 1'b0, -1, 1'b0);
    checks++; if (timeout || nw !== 4 || done_cnt !== 1) begin failures++; $display("FAIL mid_restart got words=%0d dones=%0d exp=4/1", nw, done_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_data[i] !== pat(12, i)) begin failures++; $display("FAIL mid_restart_word%0d got=%h exp=%h", i, got_data[i], pat(12, i)); end
    end
  endtask

  initial begin
    sif.out_ready = 1'b1;
    init_rf();
    test_reset();
    test_single();
    test_two_regs();
    test_wrap();
    test_full_range();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
